// File: rtl/itcm_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itcm_pkg
// Description : Shared types and default sizes for the ITCM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package itcm_pkg;

  localparam int ITCM_AW = 15;
  localparam int ITCM_DW = 32;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } itcm_state_e;

endpackage
`default_nettype wire

// File: rtl/itcm_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : itcm_resp_if
// Description : Core RAM port plus host boot-load channel of the ITCM.
// Revision    : 1.0 - initial release
// ============================================================================
interface itcm_resp_if
  import itcm_pkg::*;
#(
  parameter int AW = ITCM_AW,
  parameter int DW = ITCM_DW
);

  logic              ram_cs;
  logic              ram_w_en;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW/8-1:0]   ram_wmask;
  logic [DW-1:0]     ram_dout;
  logic              load_valid;
  logic [DW-1:0]     load_data;
  logic              load_last;
  logic              load_ready;
  logic              init_done;

  modport master (
    output ram_cs, ram_w_en, ram_addr, ram_wdata, ram_wmask,
    output load_valid, load_data, load_last,
    input  ram_dout, load_ready, init_done
  );

  modport slave (
    input  ram_cs, ram_w_en, ram_addr, ram_wdata, ram_wmask,
    input  load_valid, load_data, load_last,
    output ram_dout, load_ready, init_done
  );

endinterface
`default_nettype wire

// File: rtl/itcm_sram_1rw.sv
`default_nettype none
// ============================================================================
// Module      : itcm_sram_1rw
// Description : Single-port byte-maskable array, registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_sram_1rw
  import itcm_pkg::*;
#(
  parameter int AW = ITCM_AW,
  parameter int DW = ITCM_DW
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            en,
  input  wire logic            we,
  input  wire logic [AW-1:0]   addr,
  input  wire logic [DW-1:0]   wdata,
  input  wire logic [DW/8-1:0] wmask,
  output logic      [DW-1:0]   rdata
);

  localparam int c_nb    = DW / 8;
  localparam int c_depth = 1 << AW;

  logic [DW-1:0] r_mem [c_depth];
  logic [DW-1:0] r_rdata;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < c_nb; b++) begin
        if (wmask[b]) begin
          r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data only moves on a read; the core relies on it holding otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (en && !we) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/itcm_resp.sv
`default_nettype none
// ============================================================================
// Module      : itcm_resp
// Description : ITCM responder: boot-load FSM, load pointer, SRAM port mux.
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_resp
  import itcm_pkg::*;
#(
  parameter int AW        = ITCM_AW,
  parameter int DW        = ITCM_DW,
  parameter bit SKIP_LOAD = 1'b0
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  itcm_resp_if.slave  bus
);

  localparam int             c_nb        = DW / 8;
  localparam logic [AW-1:0]  c_last_addr = '1;
  localparam itcm_state_e    c_rst_state = SKIP_LOAD ? RUN : LOAD;

  itcm_state_e     r_state;
  itcm_state_e     w_state_nxt;
  logic [AW-1:0]   r_ld_ptr;
  logic            r_init_done;
  logic            w_load_acc;
  logic            w_ptr_end;
  logic            w_load_ready;

  logic            w_sram_en;
  logic            w_sram_we;
  logic [AW-1:0]   w_sram_addr;
  logic [DW-1:0]   w_sram_wdata;
  logic [c_nb-1:0] w_sram_wmask;
  logic [DW-1:0]   w_rdata;

  assign w_load_acc = (r_state == LOAD) && bus.load_valid;
  assign w_ptr_end  = (r_ld_ptr == c_last_addr);

  // init_done tracks the next state so it rises together with RUN entry,
  // and a SKIP_LOAD reset still shows it low until the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_rst_state;
      r_ld_ptr    <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == RUN);
      if (w_load_acc && !w_ptr_end) begin
        r_ld_ptr <= r_ld_ptr + AW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD: begin
        if (w_load_acc && (bus.load_last || w_ptr_end)) begin
          w_state_nxt = RUN;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = c_rst_state;
    endcase
  end

  always_comb begin
    w_load_ready = 1'b0;
    w_sram_en    = 1'b0;
    w_sram_we    = 1'b0;
    w_sram_addr  = '0;
    w_sram_wdata = '0;
    w_sram_wmask = '0;
    case (r_state)
      LOAD: begin
        w_load_ready = 1'b1;
        w_sram_en    = bus.load_valid;
        w_sram_we    = 1'b1;
        w_sram_addr  = r_ld_ptr;
        w_sram_wdata = bus.load_data;
        w_sram_wmask = '1;
      end
      RUN: begin
        w_sram_en    = bus.ram_cs;
        w_sram_we    = bus.ram_w_en;
        w_sram_addr  = bus.ram_addr;
        w_sram_wdata = bus.ram_wdata;
        w_sram_wmask = bus.ram_wmask;
      end
      default: ;
    endcase
  end

  itcm_sram_1rw #(
    .AW (AW),
    .DW (DW)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_sram_en),
    .we    (w_sram_we),
    .addr  (w_sram_addr),
    .wdata (w_sram_wdata),
    .wmask (w_sram_wmask),
    .rdata (w_rdata)
  );

  assign bus.ram_dout   = w_rdata;
  assign bus.load_ready = w_load_ready;
  assign bus.init_done  = r_init_done;

endmodule
`default_nettype wire
